// File: rtl/stream_utils_pkg.sv
// Shared types and helpers for the stream_utils packet blocks.
// Provides the two-state FSM encoding and a width helper for lane index/count registers.
package stream_utils_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } state_t;

    // Returns ceil(log2(value)), never less than 1, so single-lane widths stay legal.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_downsizer_pkt_keep_count.sv
// Counts consecutive set keep bits starting at the first-emitted lane.
// Lanes after the first clear bit never contribute, even if their keep bit is set.
module stream_keep_count
    import stream_utils_pkg::*;
#(
    parameter int SCALE     = 3,
    parameter bit MSB_FIRST = 1'b0,
    parameter int NW        = clog2(SCALE + 1)
) (
    input  logic [SCALE-1:0] keep_i,
    output logic [NW-1:0]    n_o
);

    logic w_run;

    always_comb begin
        n_o   = '0;
        w_run = 1'b1;
        for (int k = 0; k < SCALE; k++) begin
            if (w_run && keep_i[MSB_FIRST ? (SCALE - 1 - k) : k]) begin
                n_o = n_o + NW'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stream_downsizer_pkt.sv
// Packet-aware downsizer: splits a DW_OUT*SCALE word into up to SCALE DW_OUT-bit beats.
// Optional STREAM_DOWNSIZER_PKT_STATS_EN adds pkt_cnt_o / drop_cnt_o statistics outputs.
module stream_downsizer_pkt
    import stream_utils_pkg::*;
#(
    parameter int DW_OUT    = 16,
    parameter int SCALE     = 3,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DW_OUT*SCALE-1:0] s_data_i,
    input  logic [SCALE-1:0]        s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [DW_OUT-1:0]       m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
`ifdef STREAM_DOWNSIZER_PKT_STATS_EN
    ,
    output logic [31:0]             pkt_cnt_o,
    output logic [15:0]             drop_cnt_o
`endif
);

    localparam int IW = clog2(SCALE);
    localparam int NW = clog2(SCALE + 1);

    state_t                  r_state, w_state_nxt;
    logic [DW_OUT*SCALE-1:0] r_data,  w_data_nxt;
    logic                    r_last,  w_last_nxt;
    logic [IW-1:0]           r_idx,   w_idx_nxt;
    logic [NW-1:0]           r_n,     w_n_nxt;

    logic [NW-1:0] w_keep_n;
    logic [NW-1:0] w_idx_ext;
    logic [IW-1:0] w_sel;
    logic          w_final;
    logic          w_accept;
    logic          w_out_hs;
    logic          w_load;

    stream_keep_count #(
        .SCALE     (SCALE),
        .MSB_FIRST (MSB_FIRST),
        .NW        (NW)
    ) u_keep_count (
        .keep_i (s_keep_i),
        .n_o    (w_keep_n)
    );

    assign w_idx_ext = NW'(r_idx);
    assign w_final   = (w_idx_ext == (r_n - NW'(1)));
    assign w_sel     = MSB_FIRST ? (IW'(SCALE - 1) - r_idx) : r_idx;

    assign m_valid_o = (r_state == ST_BUSY);
    assign m_last_o  = m_valid_o & r_last & w_final;
    // Ready is forced low during reset; the final-lane handshake reopens the input the same cycle.
    assign s_ready_o = rst_n & ((r_state == ST_EMPTY) | (m_valid_o & w_final & m_ready_i));
    assign w_accept  = s_valid_i & s_ready_o;
    assign w_out_hs  = m_valid_o & m_ready_i;

    always_comb begin
        m_data_o = '0;
        for (int k = 0; k < SCALE; k++) begin
            if (w_sel == IW'(k)) begin
                m_data_o = r_data[k*DW_OUT +: DW_OUT];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_idx_nxt   = r_idx;
        w_n_nxt     = r_n;
        w_load      = 1'b0;
        if (r_state == ST_EMPTY) begin
            w_load = w_accept;
        end else if (w_out_hs) begin
            if (w_final) begin
                w_state_nxt = ST_EMPTY;
                w_load      = w_accept;
            end else begin
                w_idx_nxt = r_idx + IW'(1);
            end
        end
        // A word with no leading keep lanes is swallowed whole, last flag included.
        if (w_load) begin
            w_data_nxt  = s_data_i;
            w_last_nxt  = s_last_i;
            w_idx_nxt   = '0;
            w_n_nxt     = w_keep_n;
            w_state_nxt = (w_keep_n != '0) ? ST_BUSY : ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_idx   <= '0;
            r_n     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
            r_idx   <= w_idx_nxt;
            r_n     <= w_n_nxt;
        end
    end

`ifdef STREAM_DOWNSIZER_PKT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_o  <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (w_out_hs && m_last_o) begin
                pkt_cnt_o <= pkt_cnt_o + 32'd1;
            end
            if (w_accept && (w_keep_n == '0)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_downsizer_pkt.sv
// Self-checking bench for stream_downsizer_pkt (DW_OUT=16, SCALE=3), LSB-first and MSB-first instances.
// Directed vector table, back-to-back, reset mid-packet and a randomised backpressure run.
module tb_stream_downsizer_pkt;

    localparam int N_VEC  = 12;
    localparam int N_RAND = 5461;

    typedef struct {
        logic            msb;
        logic [47:0]     data;
        logic [2:0]      keep;
        logic            last;
        int              nb;
        logic [2:0][15:0] beats;
        logic [2:0]      lastMask;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] sData;
    logic [2:0]  sKeep;
    logic        sLast;
    logic        sValidA, sValidB;
    logic        sReadyA, sReadyB;
    logic [15:0] mDataA, mDataB;
    logic        mLastA, mLastB;
    logic        mValidA, mValidB;
    logic        mReady;
    logic        useMsb;
`ifdef STREAM_DOWNSIZER_PKT_STATS_EN
    logic [31:0] pktCntA, pktCntB;
    logic [15:0] dropCntA, dropCntB;
`endif

    logic        sReadySel, mLastSel, mValidSel;
    logic [15:0] mDataSel;

    int checks = 0;
    int fails  = 0;

    vec_t vecs[N_VEC];

    always #5 clk = ~clk;

    assign sReadySel = useMsb ? sReadyB : sReadyA;
    assign mDataSel  = useMsb ? mDataB  : mDataA;
    assign mLastSel  = useMsb ? mLastB  : mLastA;
    assign mValidSel = useMsb ? mValidB : mValidA;

    stream_downsizer_pkt #(.DW_OUT(16), .SCALE(3), .MSB_FIRST(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (sData),
        .s_keep_i  (sKeep),
        .s_last_i  (sLast),
        .s_valid_i (sValidA),
        .s_ready_o (sReadyA),
        .m_data_o  (mDataA),
        .m_last_o  (mLastA),
        .m_valid_o (mValidA),
        .m_ready_i (mReady)
`ifdef STREAM_DOWNSIZER_PKT_STATS_EN
        ,
        .pkt_cnt_o  (pktCntA),
        .drop_cnt_o (dropCntA)
`endif
    );

    stream_downsizer_pkt #(.DW_OUT(16), .SCALE(3), .MSB_FIRST(1'b1)) dutMsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (sData),
        .s_keep_i  (sKeep),
        .s_last_i  (sLast),
        .s_valid_i (sValidB),
        .s_ready_o (sReadyB),
        .m_data_o  (mDataB),
        .m_last_o  (mLastB),
        .m_valid_o (mValidB),
        .m_ready_i (mReady)
`ifdef STREAM_DOWNSIZER_PKT_STATS_EN
        ,
        .pkt_cnt_o  (pktCntB),
        .drop_cnt_o (dropCntB)
`endif
    );

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents one word, then walks its beats at full output rate.
    task automatic applyStimulus(input vec_t v, input int id);
        @(negedge clk);
        useMsb = v.msb;
        sData  = v.data;
        sKeep  = v.keep;
        sLast  = v.last;
        mReady = 1'b1;
        if (v.msb) sValidB = 1'b1;
        else       sValidA = 1'b1;
        #1;
        checkOutput($sformatf("vec%0d_ready", id), sReadySel, 1'b1);
        @(negedge clk);
        sValidA = 1'b0;
        sValidB = 1'b0;
        for (int b = 0; b < v.nb; b++) begin
            #1;
            checkOutput($sformatf("vec%0d_valid%0d", id, b), mValidSel, 1'b1);
            checkOutput($sformatf("vec%0d_data%0d", id, b), mDataSel, v.beats[b]);
            checkOutput($sformatf("vec%0d_last%0d", id, b), mLastSel, v.lastMask[b]);
            @(negedge clk);
        end
        #1;
        checkOutput($sformatf("vec%0d_idle", id), mValidSel, 1'b0);
    endtask

    initial begin
        logic [5:0][15:0] b2b;
        logic [15:0] expData[$];
        logic        expLast[$];
        logic [15:0] prevData, gotData;
        logic        prevLast, prevStall, pending, gotLast;
        int          sent, cycles, n, expDrop, expPkt, expDropB, expPktB;

        vecs[0]  = '{1'b0, 48'hCCCC_BBBB_AAAA, 3'b111, 1'b0, 3, {16'hCCCC, 16'hBBBB, 16'hAAAA}, 3'b000};
        vecs[1]  = '{1'b0, 48'h3333_2222_1111, 3'b111, 1'b1, 3, {16'h3333, 16'h2222, 16'h1111}, 3'b100};
        vecs[2]  = '{1'b0, 48'hFFFF_5678_1234, 3'b011, 1'b1, 2, {16'h0000, 16'h5678, 16'h1234}, 3'b010};
        vecs[3]  = '{1'b0, 48'hABCD_ABCD_ABCD, 3'b000, 1'b1, 0, {16'h0000, 16'h0000, 16'h0000}, 3'b000};
        vecs[4]  = '{1'b0, 48'h5555_4444_3333, 3'b111, 1'b1, 3, {16'h5555, 16'h4444, 16'h3333}, 3'b100};
        vecs[5]  = '{1'b0, 48'h1111_9876_4321, 3'b101, 1'b1, 1, {16'h0000, 16'h0000, 16'h4321}, 3'b001};
        vecs[6]  = '{1'b0, 48'h2222_3333_4444, 3'b010, 1'b0, 0, {16'h0000, 16'h0000, 16'h0000}, 3'b000};
        vecs[7]  = '{1'b0, 48'h0000_0000_0007, 3'b001, 1'b0, 1, {16'h0000, 16'h0000, 16'h0007}, 3'b000};
        vecs[8]  = '{1'b1, 48'h9999_8888_7777, 3'b110, 1'b1, 2, {16'h0000, 16'h8888, 16'h9999}, 3'b010};
        vecs[9]  = '{1'b1, 48'h9999_8888_7777, 3'b011, 1'b1, 0, {16'h0000, 16'h0000, 16'h0000}, 3'b000};
        vecs[10] = '{1'b1, 48'hC0DE_BEEF_F00D, 3'b111, 1'b0, 3, {16'hF00D, 16'hBEEF, 16'hC0DE}, 3'b000};
        vecs[11] = '{1'b1, 48'h1234_5678_9ABC, 3'b100, 1'b1, 1, {16'h0000, 16'h0000, 16'h1234}, 3'b001};

        rst_n   = 1'b0;
        sData   = '0;
        sKeep   = '0;
        sLast   = 1'b0;
        sValidA = 1'b0;
        sValidB = 1'b0;
        mReady  = 1'b0;
        useMsb  = 1'b0;
        #1;
        checkOutput("rst_valid", mValidA, 1'b0);
        checkOutput("rst_last", mLastA, 1'b0);
        checkOutput("rst_data", mDataA, 16'h0000);
        checkOutput("rst_ready", sReadyA, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", sReadyA, 1'b1);
        checkOutput("post_rst_valid", mValidA, 1'b0);

        for (int i = 0; i < N_VEC; i++) begin
            applyStimulus(vecs[i], i);
        end

        expDrop = 0; expPkt = 0; expDropB = 0; expPktB = 0;
        for (int i = 0; i < N_VEC; i++) begin
            if (!vecs[i].msb) begin
                if (vecs[i].nb == 0) expDrop++;
                else if (vecs[i].last) expPkt++;
            end else begin
                if (vecs[i].nb == 0) expDropB++;
                else if (vecs[i].last) expPktB++;
            end
        end
`ifdef STREAM_DOWNSIZER_PKT_STATS_EN
        checkOutput("stats_drop", dropCntA, 48'(expDrop));
        checkOutput("stats_pkt", pktCntA, 48'(expPkt));
        checkOutput("stats_drop_msb", dropCntB, 48'(expDropB));
        checkOutput("stats_pkt_msb", pktCntB, 48'(expPktB));
`endif

        // Two full words back-to-back: six beats with no bubble.
        b2b = {16'h3333, 16'h2222, 16'h1111, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        @(negedge clk);
        useMsb  = 1'b0;
        mReady  = 1'b1;
        sData   = 48'hCCCC_BBBB_AAAA;
        sKeep   = 3'b111;
        sLast   = 1'b0;
        sValidA = 1'b1;
        @(negedge clk);
        sData = 48'h3333_2222_1111;
        sLast = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) sValidA = 1'b0;
            #1;
            checkOutput($sformatf("b2b_valid%0d", c), mValidA, 1'b1);
            checkOutput($sformatf("b2b_data%0d", c), mDataA, b2b[c]);
            checkOutput($sformatf("b2b_last%0d", c), mLastA, (c == 5));
            checkOutput($sformatf("b2b_ready%0d", c), sReadyA, (c % 3 == 2));
            @(negedge clk);
        end
        #1;
        checkOutput("b2b_idle", mValidA, 1'b0);

        // Reset while beat 1 of 3 is on the output.
        @(negedge clk);
        sData   = 48'h0C0C_0B0B_0A0A;
        sKeep   = 3'b111;
        sLast   = 1'b1;
        sValidA = 1'b1;
        @(negedge clk);
        sValidA = 1'b0;
        #1;
        checkOutput("mid_beat0", mDataA, 16'h0A0A);
        @(negedge clk);
        #1;
        checkOutput("mid_beat1", mDataA, 16'h0B0B);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", mValidA, 1'b0);
        checkOutput("mid_rst_last", mLastA, 1'b0);
        checkOutput("mid_rst_data", mDataA, 16'h0000);
        checkOutput("mid_rst_ready", sReadyA, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_rel_ready", sReadyA, 1'b1);
        checkOutput("mid_rel_valid", mValidA, 1'b0);
        applyStimulus('{1'b0, 48'h0F0F_0E0E_0D0D, 3'b111, 1'b1, 3,
                        {16'h0F0F, 16'h0E0E, 16'h0D0D}, 3'b100}, 99);

        // Random words with random keep, 70% valid and 50% ready, against a queue model.
        useMsb    = 1'b0;
        sent      = 0;
        cycles    = 0;
        pending   = 1'b0;
        prevStall = 1'b0;
        prevData  = '0;
        prevLast  = 1'b0;
        while ((sent < N_RAND || pending || expData.size() > 0) && cycles < 80000) begin
            @(negedge clk);
            cycles++;
            mReady = ($urandom_range(0, 1) == 1);
            if (!pending && sent < N_RAND && $urandom_range(0, 9) < 7) begin
                sData   = {16'($urandom), 16'($urandom), 16'($urandom)};
                sKeep   = 3'($urandom_range(0, 7));
                sLast   = 1'($urandom_range(0, 1));
                pending = 1'b1;
                sent++;
            end
            sValidA = pending;
            #1;
            if (prevStall) begin
                checkOutput("rnd_stall_valid", mValidA, 1'b1);
                checkOutput("rnd_stall_data", mDataA, prevData);
                checkOutput("rnd_stall_last", mLastA, prevLast);
            end
            if (mValidA && mReady) begin
                if (expData.size() == 0) begin
                    checkOutput("rnd_unexpected_beat", mValidA, 1'b0);
                end else begin
                    gotData = expData.pop_front();
                    gotLast = expLast.pop_front();
                    checkOutput("rnd_data", mDataA, gotData);
                    checkOutput("rnd_last", mLastA, gotLast);
                end
            end
            prevStall = mValidA && !mReady;
            prevData  = mDataA;
            prevLast  = mLastA;
            if (sValidA && sReadyA) begin
                n = 0;
                while (n < 3 && sKeep[n]) n++;
                for (int k = 0; k < n; k++) begin
                    expData.push_back(sData[k*16 +: 16]);
                    expLast.push_back(sLast && (k == n - 1));
                end
                pending = 1'b0;
            end
        end
        checkOutput("rnd_timeout", (cycles >= 80000), 1'b0);
        checkOutput("rnd_all_sent", sent, N_RAND);
        @(negedge clk);
        sValidA = 1'b0;
        mReady  = 1'b1;
        #1;
        checkOutput("rnd_drained", mValidA, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
